// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, mt/mf selectors, default latencies and the `Word width macro.
`ifndef Word
`define Word 32
`endif

package mdu_hilo_pkg;

  localparam int WORD = `Word;

  // MulOpE encodings; 9..15 are not named and behave as no operation.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MADD  = 4'd5,
    MDU_MADDU = 4'd6,
    MDU_MSUB  = 4'd7,
    MDU_MSUBU = 4'd8
  } mdu_op_e;

  // MTHILOE / MFHILOE encodings share the same two-bit layout.
  typedef enum logic [1:0] {
    HILO_NONE = 2'b00,
    HILO_LO   = 2'b01,
    HILO_HI   = 2'b10
  } hilo_sel_e;

  localparam int MDU_MUL_CYCLES = 5;
  localparam int MDU_DIV_CYCLES = 10;

endpackage

// File: rtl/mdu_hilo_core.sv
// mdu_core: purely combinational 64-bit result for one MDU operation.
// Produces {phi_o, plo_o} from the operands and the current HI/LO.
// Accumulate operations exist only when MDU_MADD_EN is defined.
module mdu_core
  import mdu_hilo_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [WORD-1:0] a_i,
  input  logic [WORD-1:0] b_i,
  input  logic [WORD-1:0] hi_i,
  input  logic [WORD-1:0] lo_i,
  output logic [WORD-1:0] phi_o,
  output logic [WORD-1:0] plo_o
);

  logic [2*WORD-1:0]        prodS;
  logic [2*WORD-1:0]        prodU;
  logic signed [WORD-1:0]   divA;
  logic signed [WORD-1:0]   divB;
  logic [WORD-1:0]          bSafe;
  logic [WORD-1:0]          qS;
  logic [WORD-1:0]          rS;
  logic [WORD-1:0]          qU;
  logic [WORD-1:0]          rU;
  logic                     divZero;
  logic                     divOvf;
  logic [2*WORD-1:0]        hilo;

  // Products, quotients and remainders; a zero divisor is replaced by one so
  // the dividers never see it, and the result mux below discards that value.
  always_comb begin
    hilo    = {hi_i, lo_i};
    prodS   = {{WORD{a_i[WORD-1]}}, a_i} * {{WORD{b_i[WORD-1]}}, b_i};
    prodU   = {{WORD{1'b0}}, a_i} * {{WORD{1'b0}}, b_i};
    divZero = (b_i == '0);
    divOvf  = (a_i == {1'b1, {(WORD-1){1'b0}}}) && (b_i == '1);
    bSafe   = divZero ? {{(WORD-1){1'b0}}, 1'b1} : b_i;
    divA    = $signed(a_i);
    divB    = $signed(bSafe);
    qS      = divA / divB;
    rS      = divA % divB;
    qU      = a_i / bSafe;
    rU      = a_i % bSafe;
  end

  // Select the pending {HI,LO} value for the requested operation.
  always_comb begin
    {phi_o, plo_o} = hilo;
    case (op_i)
      MDU_MULT:  {phi_o, plo_o} = prodS;
      MDU_MULTU: {phi_o, plo_o} = prodU;
      MDU_DIV: begin
        if (divZero) begin
          {phi_o, plo_o} = hilo;
        end else if (divOvf) begin
          phi_o = '0;
          plo_o = {1'b1, {(WORD-1){1'b0}}};
        end else begin
          phi_o = rS;
          plo_o = qS;
        end
      end
      MDU_DIVU: begin
        if (divZero) begin
          {phi_o, plo_o} = hilo;
        end else begin
          phi_o = rU;
          plo_o = qU;
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {phi_o, plo_o} = hilo + prodS;
      MDU_MADDU: {phi_o, plo_o} = hilo + prodU;
      MDU_MSUB:  {phi_o, plo_o} = hilo - prodS;
      MDU_MSUBU: {phi_o, plo_o} = hilo - prodU;
`endif
      default: {phi_o, plo_o} = hilo;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: execute-stage multiply/divide unit owning the HI/LO registers.
// Sequences multi-cycle operations (counter, busy, commit), handles mthi/mtlo
// and supplies mfhi/mflo data. Define MDU_MADD_EN to enable madd/msub ops.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      MulOpE,
  input  logic [1:0]      MTHILOE,
  input  logic [1:0]      MFHILOE,
  input  logic [WORD-1:0] SrcAE,
  input  logic [WORD-1:0] SrcBE,
  input  logic            ExcFlush,
  output logic            Start,
  output logic            Busy,
  output logic [WORD-1:0] HILOReadE,
  output logic [WORD-1:0] HI,
  output logic [WORD-1:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [WORD-1:0]  hi_q, hi_d;
  logic [WORD-1:0]  lo_q, lo_d;
  logic [WORD-1:0]  phi_q, phi_d;
  logic [WORD-1:0]  plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             opValid;
  logic             isDiv;
  logic [WORD-1:0]  corePhi;
  logic [WORD-1:0]  corePlo;

  mdu_core u_core (
    .op_i  (MulOpE),
    .a_i   (SrcAE),
    .b_i   (SrcBE),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .phi_o (corePhi),
    .plo_o (corePlo)
  );

  // Decode which MulOpE values start an operation and which use the divider latency.
  always_comb begin
    opValid = 1'b0;
    isDiv   = 1'b0;
    case (MulOpE)
      MDU_MULT, MDU_MULTU: opValid = 1'b1;
      MDU_DIV, MDU_DIVU: begin
        opValid = 1'b1;
        isDiv   = 1'b1;
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: opValid = 1'b1;
`endif
      default: ;
    endcase
  end

  // Handshake outputs and the zero-latency mf read port.
  always_comb begin
    Start = opValid & ~busy_q & ~ExcFlush;
    Busy  = Start | busy_q;
    case (MFHILOE)
      HILO_HI: HILOReadE = hi_q;
      HILO_LO: HILOReadE = lo_q;
      default: HILOReadE = '0;
    endcase
    HI = hi_q;
    LO = lo_q;
  end

  // Next state: capture on Start, count down while busy, commit at count one,
  // and apply mthi/mtlo only when idle and not flushed.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (Start) begin
      phi_d  = corePhi;
      plo_d  = corePlo;
      cnt_d  = isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        hi_d   = phi_q;
        lo_d   = plo_q;
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    if (!busy_q && !ExcFlush) begin
      if (MTHILOE == HILO_HI) begin
        hi_d = SrcAE;
      end else if (MTHILOE == HILO_LO) begin
        lo_d = SrcAE;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed scenarios followed by random
// traffic, every cycle compared against a behavioural HI/LO model.
module tb_mdu_hilo;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MulOpE;
  logic [1:0]  MTHILOE;
  logic [1:0]  MFHILOE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        ExcFlush;
  logic        Start;
  logic        Busy;
  logic [31:0] HILOReadE;
  logic [31:0] HI;
  logic [31:0] LO;

  int testsRun  = 0;
  int failCount = 0;

  // Behavioural model state
  logic [31:0] mHi, mLo;
  logic [63:0] mPend;
  bit          mBusy;
  int          mLeft;

  logic sampledBusy;
  logic sampledStart;

  mdu_hilo #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk       (clk),
    .reset     (reset),
    .MulOpE    (MulOpE),
    .MTHILOE   (MTHILOE),
    .MFHILOE   (MFHILOE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .ExcFlush  (ExcFlush),
    .Start     (Start),
    .Busy      (Busy),
    .HILOReadE (HILOReadE),
    .HI        (HI),
    .LO        (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit opIsValid(input int op);
`ifdef MDU_MADD_EN
    return (op >= 1) && (op <= 8);
`else
    return (op >= 1) && (op <= 4);
`endif
  endfunction

  // Reference arithmetic with 64-bit integers straight from the operation rules.
  function automatic logic [63:0] refResult(input int op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    int          sa, sb;
    longint      ps, q, r;
    logic [63:0] pu, cur;
    sa  = a;
    sb  = b;
    ps  = longint'(sa) * longint'(sb);
    pu  = 64'(a) * 64'(b);
    cur = {hi, lo};
    case (op)
      1: return ps;
      2: return pu;
      3: begin
        if (b == 0) return cur;
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) % longint'(sb);
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (b == 0) return cur;
        return {a % b, a / b};
      end
      5: return cur + ps;
      6: return cur + pu;
      7: return cur - ps;
      8: return cur - pu;
      default: return cur;
    endcase
  endfunction

  // Drive one cycle on the falling edge, check combinational outputs, advance model at the rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] mt, input logic [1:0] mf,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic fl, input logic rs);
    bit          expStart, wasBusy;
    logic [31:0] expRead;
    @(negedge clk);
    MulOpE   = op;
    MTHILOE  = mt;
    MFHILOE  = mf;
    SrcAE    = a;
    SrcBE    = b;
    ExcFlush = fl;
    reset    = rs;
    #1;
    expStart = opIsValid(int'(op)) && !mBusy && !fl;
    expRead  = (mf == 2'b10) ? mHi : (mf == 2'b01) ? mLo : 32'h0;
    checkOutput("start", {31'b0, Start}, {31'b0, expStart});
    checkOutput("busy", {31'b0, Busy}, {31'b0, (expStart || mBusy)});
    checkOutput("hiloread", HILOReadE, expRead);
    checkOutput("hi", HI, mHi);
    checkOutput("lo", LO, mLo);
    sampledBusy  = Busy;
    sampledStart = Start;
    @(posedge clk);
    if (rs) begin
      mHi = 0; mLo = 0; mPend = 0; mBusy = 0; mLeft = 0;
    end else begin
      wasBusy = mBusy;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mHi   = mPend[63:32];
          mLo   = mPend[31:0];
          mBusy = 0;
        end
      end else if (expStart) begin
        mPend = refResult(int'(op), a, b, mHi, mLo);
        mLeft = (op == 4'd3 || op == 4'd4) ? DIVN : MULN;
        mBusy = 1;
      end
      if (!wasBusy && !fl) begin
        if (mt == 2'b10) mHi = a;
        else if (mt == 2'b01) mLo = a;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(4'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Issue one operation and count the cycles Busy is observed high (bounded).
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    applyStimulus(op, 2'b00, 2'b00, a, b, 1'b0, 1'b0);
    n = sampledBusy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!sampledBusy) break;
      n++;
    end
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] eHi, input logic [31:0] eLo);
    #2;
    checkOutput({tag, "_hi"}, HI, eHi);
    checkOutput({tag, "_lo"}, LO, eLo);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials [6];
    specials[0] = 32'h0;
    specials[1] = 32'h1;
    specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000;
    specials[4] = 32'h7FFFFFFF;
    specials[5] = 32'h2;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int n;
    mHi = 0; mLo = 0; mPend = 0; mBusy = 0; mLeft = 0;
    MulOpE = 0; MTHILOE = 0; MFHILOE = 0; SrcAE = 0; SrcBE = 0; ExcFlush = 0; reset = 1;

    applyStimulus(4'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(4'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    checkRegs("reset", 32'h0, 32'h0);
    checkOutput("reset_busy", {31'b0, Busy}, 32'h0);

    runOp(4'd1, 32'hFFFFFFFE, 32'd3, n);
    checkOutput("mult_busy_cycles", n, MULN + 1);
    checkRegs("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    runOp(4'd2, 32'hFFFFFFFE, 32'd3, n);
    checkRegs("multu", 32'h00000002, 32'hFFFFFFFA);

    runOp(4'd3, 32'hFFFFFFF9, 32'd2, n);
    checkOutput("div_busy_cycles", n, DIVN + 1);
    checkRegs("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    runOp(4'd4, 32'd7, 32'd0, n);
    checkRegs("divu_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);

    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checkRegs("div_ovf", 32'h0, 32'h80000000);

    applyStimulus(4'd0, 2'b10, 2'b00, 32'h12345678, 32'h0, 1'b0, 1'b0);
    applyStimulus(4'd0, 2'b00, 2'b10, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("mfhi", HILOReadE, 32'h12345678);

    applyStimulus(4'd1, 2'b00, 2'b00, 32'h5, 32'h7, 1'b1, 1'b0);
    checkOutput("flush_start", {31'b0, sampledStart}, 32'h0);
    checkOutput("flush_busy", {31'b0, sampledBusy}, 32'h0);
    idle();
    checkRegs("flush", 32'h12345678, 32'h80000000);

`ifdef MDU_MADD_EN
    applyStimulus(4'd0, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(4'd0, 2'b01, 2'b00, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    runOp(4'd5, 32'd1, 32'd1, n);
    checkRegs("madd", 32'h1, 32'h0);
    applyStimulus(4'd0, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(4'd0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    runOp(4'd8, 32'd1, 32'd1, n);
    checkRegs("msubu", 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    applyStimulus(4'd5, 2'b00, 2'b00, 32'd1, 32'd1, 1'b0, 1'b0);
    checkOutput("madd_off_busy", {31'b0, sampledBusy}, 32'h0);
    idle();
    checkRegs("madd_off", 32'h12345678, 32'h80000000);
`endif

    // Second op while busy is ignored; the first commits on schedule.
    applyStimulus(4'd1, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    applyStimulus(4'd2, 2'b00, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0);
    n = 2;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (!sampledBusy) break;
      n++;
    end
    checkOutput("busy_ignore_cycles", n, MULN + 1);
    checkRegs("busy_ignore", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // Reset while the counter holds 3 discards the pending result.
    applyStimulus(4'd1, 2'b00, 2'b00, 32'd3, 32'd3, 1'b0, 1'b0);
    idle();
    idle();
    applyStimulus(4'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    checkRegs("midreset", 32'h0, 32'h0);
    checkOutput("midreset_busy", {31'b0, Busy}, 32'h0);
    for (int i = 0; i < 10; i++) idle();
    checkRegs("midreset_late", 32'h0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [1:0]  mt;
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      mt = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(op, mt, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
